// File: rtl/axis_burst_write_scheduler.sv
// Drains per-packet word counts and data words from FWFT FIFOs and issues them as
// AXI4 write bursts (length-capped, 4 KB-safe, bounded outstanding responses).
module axis_burst_write_scheduler #(
    parameter int DATA_W          = 32,
    parameter int ADDR_W          = 64,
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    input  logic                ap_start,
    output logic                ap_done,
    output logic                ap_idle,
    output logic                ap_ready,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [31:0]         count_dout,
    input  logic                count_empty_n,
    output logic                count_read,
    input  logic [DATA_W-1:0]   buf_dout,
    input  logic                buf_empty_n,
    output logic                buf_read,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [7:0]          m_axi_awlen,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wlast,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    input  logic [1:0]          m_axi_bresp,
    output logic                err
);

    localparam int BYTES      = DATA_W / 8;
    localparam int BYTE_SHIFT = $clog2(BYTES);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_GET_CNT  = 3'd1;
    localparam logic [2:0] S_CALC     = 3'd2;
    localparam logic [2:0] S_ISSUE_AW = 3'd3;
    localparam logic [2:0] S_SEND_W   = 3'd4;
    localparam logic [2:0] S_DRAIN_B  = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    logic [2:0]        state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [31:0]       rem_reg, rem_next;
    logic [7:0]        len_m1_reg, len_m1_next;
    logic [7:0]        beat_reg, beat_next;
    logic [3:0]        outstanding_reg, outstanding_next;
    logic              err_reg, err_next;

    logic              aw_hs, w_hs, b_hs, last_beat;
    logic [12:0]       room_bytes, boundary_beats, len_calc;
    logic [8:0]        burst_len;
    logic [31:0]       burst_len32;
    logic [ADDR_W-1:0] burst_bytes;

    assign ap_idle       = (state_reg == S_IDLE);
    assign ap_done       = (state_reg == S_DONE);
    assign ap_ready      = (state_reg == S_DONE);
    assign count_read    = (state_reg == S_GET_CNT) && count_empty_n;
    assign m_axi_awvalid = (state_reg == S_ISSUE_AW) && (outstanding_reg < 4'(MAX_OUTSTANDING));
    assign m_axi_awaddr  = addr_reg;
    assign m_axi_awlen   = len_m1_reg;
    assign m_axi_wvalid  = (state_reg == S_SEND_W) && buf_empty_n;
    assign m_axi_wdata   = buf_dout;
    assign last_beat     = (beat_reg == len_m1_reg);
    assign m_axi_wlast   = (state_reg == S_SEND_W) && last_beat;
    assign buf_read      = m_axi_wvalid && m_axi_wready;
    assign m_axi_bready  = (outstanding_reg != 4'd0);
    assign err           = err_reg;

    assign aw_hs = m_axi_awvalid && m_axi_awready;
    assign w_hs  = m_axi_wvalid && m_axi_wready;
    assign b_hs  = m_axi_bvalid && m_axi_bready;

    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_strb
            assign m_axi_wstrb[gi] = 1'b1;
        end
    endgenerate

    // Beats left before the next 4 KB page, clipped by MAX_BURST and the remaining count.
    always_comb begin
        room_bytes     = 13'd4096 - {1'b0, addr_reg[11:0]};
        boundary_beats = room_bytes >> BYTE_SHIFT;
        len_calc       = 13'(MAX_BURST);
        if (boundary_beats < len_calc) begin
            len_calc = boundary_beats;
        end
        if (rem_reg < 32'(len_calc)) begin
            len_calc = rem_reg[12:0];
        end
    end

    assign burst_len   = {1'b0, len_m1_reg} + 9'd1;
    assign burst_len32 = 32'(burst_len);
    assign burst_bytes = ADDR_W'(burst_len) << BYTE_SHIFT;

    always_comb begin
        state_next       = state_reg;
        addr_next        = addr_reg;
        rem_next         = rem_reg;
        len_m1_next      = len_m1_reg;
        beat_next        = beat_reg;
        outstanding_next = outstanding_reg;
        err_next         = err_reg;

        case (state_reg)
            S_IDLE: begin
                if (ap_start) begin
                    addr_next  = base_addr & ~ADDR_W'(BYTES - 1);
                    err_next   = 1'b0;
                    state_next = S_GET_CNT;
                end
            end
            S_GET_CNT: begin
                if (count_empty_n) begin
                    rem_next   = count_dout;
                    state_next = (count_dout == 32'd0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                len_m1_next = 8'(len_calc - 13'd1);
                state_next  = S_ISSUE_AW;
            end
            S_ISSUE_AW: begin
                if (aw_hs) begin
                    beat_next  = 8'd0;
                    state_next = S_SEND_W;
                end
            end
            S_SEND_W: begin
                if (w_hs) begin
                    if (last_beat) begin
                        addr_next  = addr_reg + burst_bytes;
                        rem_next   = rem_reg - burst_len32;
                        state_next = (rem_reg == burst_len32) ? S_DRAIN_B : S_CALC;
                    end else begin
                        beat_next = beat_reg + 8'd1;
                    end
                end
            end
            S_DRAIN_B: begin
                if (outstanding_reg == 4'd0) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Response bookkeeping runs in every state; simultaneous AW and B cancel out.
        if (aw_hs && !b_hs) begin
            outstanding_next = outstanding_reg + 4'd1;
        end else if (b_hs && !aw_hs) begin
            outstanding_next = outstanding_reg - 4'd1;
        end
        if (b_hs && (m_axi_bresp != 2'b00)) begin
            err_next = 1'b1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_reg       <= S_IDLE;
            addr_reg        <= '0;
            rem_reg         <= '0;
            len_m1_reg      <= '0;
            beat_reg        <= '0;
            outstanding_reg <= '0;
            err_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            addr_reg        <= addr_next;
            rem_reg         <= rem_next;
            len_m1_reg      <= len_m1_next;
            beat_reg        <= beat_next;
            outstanding_reg <= outstanding_next;
            err_reg         <= err_next;
        end
    end

endmodule
